// File: rtl/irq_onehot_arbiter_if.sv
// Interface between the request/mask/ack side and the arbiter.
// The master drives the requests and the acknowledge; the slave (the arbiter) drives the grant and status.
interface irq_onehot_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [WIDTH-1:0] a;
  logic             en;
  logic [WIDTH-1:0] pending;
  logic             busy;
  logic             overrun;

  modport master (
    output req, mask, ack,
    input  a, en, pending, busy, overrun
  );

  modport slave (
    input  req, mask, ack,
    output a, en, pending, busy, overrun
  );
endinterface

// File: rtl/irq_onehot_arbiter.sv
// Captures rising edges on request lines as pending events.
// Presents the highest-priority unmasked event as a registered one-hot grant for the 8-to-3 encoder.
module irq_onehot_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_onehot_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] req_q_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] a_reg;
  logic             en_reg;
  logic             overrun_reg;

  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] retire;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] pending_next;

  assign edge_vec     = bus.req & ~req_q_reg;
  assign eligible     = pending_reg & ~bus.mask;
  assign retire       = (state_reg == PRESENT && bus.ack) ? a_reg : '0;
  // A new edge on the bit being retired re-arms it: set wins over clear.
  assign pending_next = (pending_reg & ~retire) | edge_vec;

  // Bit gi wins only if no higher-numbered bit is eligible.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pick
      assign pick[gi] = eligible[gi] & ~(|(eligible >> (gi + 1)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      req_q_reg   <= '0;
      pending_reg <= '0;
      a_reg       <= '0;
      en_reg      <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      req_q_reg   <= bus.req;
      pending_reg <= pending_next;
      overrun_reg <= overrun_reg | (|(edge_vec & pending_reg));
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            a_reg     <= pick;
            en_reg    <= 1'b1;
            state_reg <= PRESENT;
          end else begin
            a_reg  <= '0;
            en_reg <= 1'b0;
          end
        end
        PRESENT: begin
          // Grant is frozen here; only ack can end it.
          if (bus.ack) begin
            a_reg     <= '0;
            en_reg    <= 1'b0;
            state_reg <= GAP;
          end
        end
        GAP: begin
          state_reg <= IDLE;
        end
        default: begin
          a_reg     <= '0;
          en_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.a       = a_reg;
  assign bus.en      = en_reg;
  assign bus.pending = pending_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Scoreboard bench for irq_onehot_arbiter: expected grants are queued with the stimulus
// and popped as each grant appears.
module tb_irq_onehot_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] sb[$];

  irq_onehot_arbiter_if #(.WIDTH(8)) bus ();

  irq_onehot_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Waits on negedges for en; exp_low is the number of en-low samples expected first (-1: don't care).
  task automatic wait_grant(input string tag, input int exp_low);
    int   n_low;
    bit   got;
    logic [7:0] exp_a;
    n_low = 0;
    got   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.en) got = 1;
      else n_low++;
    end
    check({tag, "_timeout"}, int'(got), 1);
    if (got) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 1, 0);
      end else begin
        exp_a = sb.pop_front();
        check({tag, "_a"}, int'(bus.a), int'(exp_a));
        check({tag, "_onehot"}, int'($onehot(bus.a)), 1);
        if (exp_low >= 0) check({tag, "_latency"}, n_low, exp_low);
        $display("[TB] grant %s a=%02h pending=%02h low_cycles=%0d", tag, bus.a, bus.pending, n_low);
      end
    end
  endtask

  // Called at a negedge with en=1; returns at the negedge after the ack edge.
  task automatic ack_grant(input string tag);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check({tag, "_ack_en"}, int'(bus.en), 0);
    check({tag, "_ack_a"}, int'(bus.a), 0);
    check({tag, "_ack_busy"}, int'(bus.busy), 1);
  endtask

  initial begin
    bit saw_en;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.mask = '0;
    bus.ack  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a", int'(bus.a), 0);
    check("rst_en", int'(bus.en), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    bus.req = 8'h04;
    sb.push_back(8'h04);
    @(negedge clk);
    check("single_pending", int'(bus.pending), 'h04);
    check("single_en_early", int'(bus.en), 0);
    wait_grant("single", 0);
    bus.req = '0;
    ack_grant("single");
    check("single_pending_clr", int'(bus.pending), 0);
    @(negedge clk);
    check("single_idle", int'(bus.busy), 0);

    // Simultaneous requests, priority order, 2 low cycles between grants
    bus.req = 8'h91;
    sb.push_back(8'h80);
    sb.push_back(8'h10);
    sb.push_back(8'h01);
    wait_grant("simul0", 1);
    ack_grant("simul0");
    check("simul0_pending", int'(bus.pending), 'h11);
    wait_grant("simul1", 1);
    ack_grant("simul1");
    wait_grant("simul2", 1);
    ack_grant("simul2");
    check("simul_pending_clr", int'(bus.pending), 0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Masking
    bus.mask = 8'h80;
    bus.req  = 8'h82;
    sb.push_back(8'h02);
    sb.push_back(8'h80);
    wait_grant("mask0", 1);
    check("mask0_pending7", int'(bus.pending[7]), 1);
    bus.mask = 8'h82;
    @(negedge clk);
    check("mask_hold_a", int'(bus.a), 'h02);
    check("mask_hold_en", int'(bus.en), 1);
    ack_grant("mask0");
    check("mask0_pending", int'(bus.pending), 'h80);
    bus.mask = 8'h00;
    wait_grant("mask1", 1);
    ack_grant("mask1");
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Overrun: two pulses on req[3] without ack
    check("ovr_before", int'(bus.overrun), 0);
    sb.push_back(8'h08);
    bus.req = 8'h08; @(negedge clk);
    bus.req = 8'h00; @(negedge clk);
    bus.req = 8'h08; @(negedge clk);
    bus.req = 8'h00;
    check("ovr_set", int'(bus.overrun), 1);
    wait_grant("ovr", -1);
    ack_grant("ovr");
    saw_en = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.en) saw_en = 1;
    end
    check("ovr_single_grant", int'(saw_en), 0);
    check("ovr_pending", int'(bus.pending), 0);
    check("ovr_sticky", int'(bus.overrun), 1);

    // Same-bit retrigger coincident with ack
    bus.req = 8'h20;
    sb.push_back(8'h20);
    sb.push_back(8'h20);
    wait_grant("retrig0", 1);
    bus.req = 8'h00;
    @(negedge clk);
    bus.req = 8'h20;
    ack_grant("retrig0");
    check("retrig_pending", int'(bus.pending), 'h20);
    wait_grant("retrig1", 1);
    ack_grant("retrig1");
    check("retrig_pending_clr", int'(bus.pending), 0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset mid-grant, then req held high re-edges after release
    bus.req = 8'h01;
    sb.push_back(8'h01);
    wait_grant("prerst", 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", int'(bus.a), 0);
    check("arst_en", int'(bus.en), 0);
    check("arst_pending", int'(bus.pending), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(8'h01);
    wait_grant("postrst", 1);
    ack_grant("postrst");
    bus.req = '0;
    repeat (2) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
